reorder_buffer: RTL and testbench
=================================

// Module: reorder_buffer
// PURPOSE
//   Circular in-order reorder buffer between decoder/dispatch and the architectural regfile.
//   - Allocates a ROB tag per dispatched instruction and captures CDB results.
//   - Commits one instruction per cycle to the regfile.
//   - On a mispredicted branch at head: commits it, then issues a one-cycle global flush.
//   - Tag 0 is reserved as "no rename"; live entries carry tags 1..DEPTH.
// PARAMETERS
//   ROB_W  4  tag width; DEPTH = 2**ROB_W - 1 entries (15), tag = slot index + 1
// PORTS
//   clk_in              in   1      system clock
//   rst_in              in   1      asynchronous, active-low reset
//   dispatch_valid      in   1      decoder presents an instruction
//   dispatch_ready      out  1      ROB accepts (state RUN and count < DEPTH)
//   dispatch_has_dest   in   1      instruction writes rd
//   dispatch_reg_id     in   5      rd index
//   dispatch_is_branch  in   1      entry may mispredict
//   dispatch_rob_id     out  ROB_W  tag the next accepted dispatch receives (combinational, tail+1)
//   cdb_valid           in   1      result broadcast
//   cdb_rob_id          in   ROB_W  producing tag
//   cdb_data            in   32     result value
//   cdb_mispredict      in   1      branch resolved opposite to prediction
//   cdb_redirect_pc     in   32     correct target when mispredicted
//   query_rob_id_a/b    in   ROB_W  operand tags from regfile rename table
//   query_ready_a/b     out  1      tagged entry holds its result
//   query_data_a/b      out  32     that result
//   to_rf_write_enabled out  1      registered commit strobe
//   to_rf_reg_id        out  5      committed rd
//   to_rf_data          out  32     committed value
//   to_rf_rob_id        out  ROB_W  committed tag
//   flush_out           out  1      registered one-cycle flush
//   flush_pc_out        out  32     redirect target, valid with flush_out
// BEHAVIOUR
//   Reset (rst_in low, async): head=tail=count=0, all entries invalid, state RUN.
//     All outputs 0 except dispatch_ready=1 and dispatch_rob_id=1.
//   Entry fields: busy, ready, has_dest, reg_id, is_branch, mispredict, data, redirect_pc.
//   Dispatch: valid&&ready -> slot[tail] busy, ready=0; tail wraps DEPTH-1->0; count+1.
//   CDB: valid with tag!=0 and slot busy -> data, ready=1, mispredict latched.
//     Tag 0 or non-busy slot: ignored.
//   Commit: slot[head] busy&&ready in RUN -> next cycle to_rf_write_enabled=has_dest,
//     reg/data/tag driven; slot freed; head wraps; count-1.
//     Strobe held exactly one cycle; otherwise 0.
//   Dispatch and commit on the same edge: count unchanged.
//     dispatch_ready uses pre-edge count, so full stays not-ready that cycle.
//   CDB write to head and commit of head on the same edge: not committed until the next edge.
//   FSM RUN -> FLUSH_PEND: when the committing head has mispredict=1.
//     Its regfile write goes out first; no dispatch and no commit in FLUSH_PEND.
//   FLUSH_PEND -> RUN after one cycle: flush_out=1 and flush_pc_out=redirect_pc for that one cycle.
//     All entries cleared, head=tail=count=0.
//     Write precedes flush because the regfile drops commits during flush.
//   Query: ready = (tag!=0) && busy && ready-bit; data = slot data; tag 0 -> ready=0, data=0.
//   Async reset mid-FLUSH_PEND: aborts the flush; no flush_out is emitted.
// CONFIGURATION
//   ROB_BYPASS_EN defined: query ports also match the same-cycle CDB.
//     cdb_valid && cdb_rob_id==query tag (tag!=0, slot busy) -> ready=1, data=cdb_data.
//   Not defined: query sees registered entry state only; one extra cycle of latency.
// STRUCTURE
//   Shared package/const_def: ROB_W, DEPTH, ROB_RANGE, reserved NO_TAG=0, FSM state encoding.
//   Natural sub-module: rob_query_port, one instance per operand (tag->ready/data mux, bypass).
// TESTING
//   1. Reset then dispatch rd=5 -> dispatch_rob_id 1.
//      CDB tag1 data 0xDEADBEEF -> next cycle to_rf_write_enabled=1, reg 5, data 0xDEADBEEF, tag 1.
//   2. Dispatch 15 without CDB -> dispatch_ready=0 at count 15.
//      Complete tag1 -> commit frees slot; ready=1 the cycle after.
//   3. Wrap: 40 dispatch/complete/commit pairs -> tags cycle 1..15,1.. with no loss or reorder.
//   4. Out-of-order CDB tags 3,2,1 -> commits strictly in order 1,2,3 on consecutive cycles.
//   5. Head branch rd=1 mispredict, redirect 0x80 -> cycle N rf write reg1.
//      Cycle N+1 flush_out=1, pc 0x80; then count 0, dispatch_rob_id 1.
//   6. Query tag 2 on the same cycle as CDB tag 2 -> ready=1 only with ROB_BYPASS_EN.
//      rst_in pulsed low in FLUSH_PEND -> no flush_out.

Source files
------------

// File: rtl/reorder_buffer_pkg.sv
// Shared ROB constants, tag type, FSM encoding and entry layout.
package reorder_buffer_pkg;
    localparam int ROB_W = 4;
    localparam int DEPTH = 2**ROB_W - 1;

    typedef logic [ROB_W-1:0] rob_tag_t;
    localparam rob_tag_t NO_TAG = '0;

    typedef enum logic {RUN = 1'b0, FLUSH_PEND = 1'b1} rob_state_e;

    typedef struct packed {
        logic        busy;
        logic        ready;
        logic        has_dest;
        logic [4:0]  reg_id;
        logic        is_branch;
        logic        mispredict;
        logic [31:0] data;
        logic [31:0] redirect_pc;
    } rob_entry_t;

    function automatic rob_tag_t next_ptr(input rob_tag_t p);
        return (p == rob_tag_t'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    // Tag 0 means "no rename"; map it to slot 0 so lookups stay in range (callers gate on tag).
    function automatic rob_tag_t tag2slot(input rob_tag_t t);
        return (t == NO_TAG) ? '0 : t - 1'b1;
    endfunction
endpackage

// File: rtl/reorder_buffer_if.sv
// Dispatch, CDB, operand query, regfile commit and flush signals of the ROB.
interface reorder_buffer_if;
    import reorder_buffer_pkg::*;

    logic        dispatch_valid;
    logic        dispatch_ready;
    logic        dispatch_has_dest;
    logic [4:0]  dispatch_reg_id;
    logic        dispatch_is_branch;
    rob_tag_t    dispatch_rob_id;
    logic        cdb_valid;
    rob_tag_t    cdb_rob_id;
    logic [31:0] cdb_data;
    logic        cdb_mispredict;
    logic [31:0] cdb_redirect_pc;
    rob_tag_t    query_rob_id_a;
    rob_tag_t    query_rob_id_b;
    logic        query_ready_a;
    logic        query_ready_b;
    logic [31:0] query_data_a;
    logic [31:0] query_data_b;
    logic        to_rf_write_enabled;
    logic [4:0]  to_rf_reg_id;
    logic [31:0] to_rf_data;
    rob_tag_t    to_rf_rob_id;
    logic        flush_out;
    logic [31:0] flush_pc_out;

    modport slave (
        input  dispatch_valid, dispatch_has_dest, dispatch_reg_id, dispatch_is_branch,
               cdb_valid, cdb_rob_id, cdb_data, cdb_mispredict, cdb_redirect_pc,
               query_rob_id_a, query_rob_id_b,
        output dispatch_ready, dispatch_rob_id, query_ready_a, query_ready_b,
               query_data_a, query_data_b, to_rf_write_enabled, to_rf_reg_id,
               to_rf_data, to_rf_rob_id, flush_out, flush_pc_out
    );

    modport master (
        output dispatch_valid, dispatch_has_dest, dispatch_reg_id, dispatch_is_branch,
               cdb_valid, cdb_rob_id, cdb_data, cdb_mispredict, cdb_redirect_pc,
               query_rob_id_a, query_rob_id_b,
        input  dispatch_ready, dispatch_rob_id, query_ready_a, query_ready_b,
               query_data_a, query_data_b, to_rf_write_enabled, to_rf_reg_id,
               to_rf_data, to_rf_rob_id, flush_out, flush_pc_out
    );
endinterface

// File: rtl/reorder_buffer_query_port.sv
// One operand lookup: tag -> ready/data, with an optional same-cycle CDB match.
// The top drives byp_valid low unless ROB_BYPASS_EN is defined.
module reorder_buffer_query_port
    import reorder_buffer_pkg::*;
(
    input  rob_tag_t               tag,
    input  logic [DEPTH-1:0]       busy,
    input  logic [DEPTH-1:0]       ready,
    input  logic [DEPTH-1:0][31:0] data,
    input  logic                   byp_valid,
    input  rob_tag_t               byp_tag,
    input  logic [31:0]            byp_data,
    output logic                   q_ready,
    output logic [31:0]            q_data
);
    rob_tag_t slot;
    logic     live;

    always_comb begin
        slot    = tag2slot(tag);
        live    = (tag != NO_TAG) && busy[slot];
        q_ready = live && ready[slot];
        q_data  = (tag != NO_TAG) ? data[slot] : '0;
        if (live && byp_valid && (byp_tag == tag)) begin
            q_ready = 1'b1;
            q_data  = byp_data;
        end
    end
endmodule

// File: rtl/reorder_buffer.sv
// Circular in-order reorder buffer: tag allocation, CDB capture, one commit per cycle,
// and a registered flush after a mispredicted branch commits. ROB_BYPASS_EN adds CDB bypass on queries.
module reorder_buffer
    import reorder_buffer_pkg::*;
(
    input  logic            clk_in,
    input  logic            rst_in,
    reorder_buffer_if.slave rob
);
    rob_entry_t [DEPTH-1:0]  slots;
    rob_tag_t                head, tail, count, cdb_slot;
    rob_state_e              state_q, state_d;
    logic [31:0]             flush_pc_q;
    logic                    dispatch_fire, commit_fire, cdb_hit, flush_go, byp_valid;
    rob_entry_t              head_e;
    logic [DEPTH-1:0]        s_busy, s_ready;
    logic [DEPTH-1:0][31:0]  s_data;

    assign head_e              = slots[head];
    assign rob.dispatch_ready  = (state_q == RUN) && (count < rob_tag_t'(DEPTH));
    assign rob.dispatch_rob_id = tail + 1'b1;
    assign dispatch_fire       = rob.dispatch_valid && rob.dispatch_ready;
    assign commit_fire         = (state_q == RUN) && head_e.busy && head_e.ready;
    assign cdb_slot            = tag2slot(rob.cdb_rob_id);
    assign cdb_hit             = rob.cdb_valid && (rob.cdb_rob_id != NO_TAG) && slots[cdb_slot].busy;

    always_comb begin
        state_d  = state_q;
        flush_go = 1'b0;
        case (state_q)
            RUN:        if (commit_fire && head_e.mispredict) state_d = FLUSH_PEND;
            FLUSH_PEND: begin
                state_d  = RUN;
                flush_go = 1'b1;
            end
            default:    state_d = RUN;
        endcase
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_q <= RUN;
        else         state_q <= state_d;
    end

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            slots                   <= '0;
            head                    <= '0;
            tail                    <= '0;
            count                   <= '0;
            flush_pc_q              <= '0;
            rob.to_rf_write_enabled <= 1'b0;
            rob.to_rf_reg_id        <= '0;
            rob.to_rf_data          <= '0;
            rob.to_rf_rob_id        <= '0;
            rob.flush_out           <= 1'b0;
            rob.flush_pc_out        <= '0;
        end else begin
            rob.to_rf_write_enabled <= commit_fire && head_e.has_dest;
            rob.to_rf_reg_id        <= commit_fire ? head_e.reg_id : '0;
            rob.to_rf_data          <= commit_fire ? head_e.data : '0;
            rob.to_rf_rob_id        <= commit_fire ? head + 1'b1 : '0;
            rob.flush_out           <= flush_go;
            rob.flush_pc_out        <= flush_go ? flush_pc_q : '0;
            if (flush_go) begin
                slots <= '0;
                head  <= '0;
                tail  <= '0;
                count <= '0;
            end else begin
                if (dispatch_fire) begin
                    slots[tail] <= '{busy: 1'b1, ready: 1'b0, has_dest: rob.dispatch_has_dest,
                                     reg_id: rob.dispatch_reg_id, is_branch: rob.dispatch_is_branch,
                                     mispredict: 1'b0, data: '0, redirect_pc: '0};
                    tail <= next_ptr(tail);
                end
                if (cdb_hit) begin
                    slots[cdb_slot].ready       <= 1'b1;
                    slots[cdb_slot].data        <= rob.cdb_data;
                    slots[cdb_slot].mispredict  <= rob.cdb_mispredict && slots[cdb_slot].is_branch;
                    slots[cdb_slot].redirect_pc <= rob.cdb_redirect_pc;
                end
                // Freeing the head is written last so it beats a redundant CDB to the same slot.
                if (commit_fire) begin
                    slots[head] <= '0;
                    head        <= next_ptr(head);
                    if (head_e.mispredict) flush_pc_q <= head_e.redirect_pc;
                end
                if (dispatch_fire && !commit_fire)      count <= count + 1'b1;
                else if (!dispatch_fire && commit_fire) count <= count - 1'b1;
            end
        end
    end

    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            s_busy[i]  = slots[i].busy;
            s_ready[i] = slots[i].ready;
            s_data[i]  = slots[i].data;
        end
    end

`ifdef ROB_BYPASS_EN
    assign byp_valid = rob.cdb_valid;
`else
    assign byp_valid = 1'b0;
`endif

    reorder_buffer_query_port u_query_a (
        .tag(rob.query_rob_id_a), .busy(s_busy), .ready(s_ready), .data(s_data),
        .byp_valid(byp_valid), .byp_tag(rob.cdb_rob_id), .byp_data(rob.cdb_data),
        .q_ready(rob.query_ready_a), .q_data(rob.query_data_a)
    );

    reorder_buffer_query_port u_query_b (
        .tag(rob.query_rob_id_b), .busy(s_busy), .ready(s_ready), .data(s_data),
        .byp_valid(byp_valid), .byp_tag(rob.cdb_rob_id), .byp_data(rob.cdb_data),
        .q_ready(rob.query_ready_b), .q_data(rob.query_data_b)
    );
endmodule

// File: tb/tb_reorder_buffer.sv
// Bench for reorder_buffer: in-order queue model checked every cycle plus directed literal checks.
module tb_reorder_buffer;
    import reorder_buffer_pkg::*;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    reorder_buffer_if rob();
    reorder_buffer dut (.clk_in(clk), .rst_in(rst_n), .rob(rob));

    int n_cmp = 0;
    int n_err = 0;

    typedef struct {
        rob_tag_t    tag;
        logic        hd;
        logic [4:0]  rg;
        logic        br;
        logic        done;
        logic [31:0] data;
        logic        mp;
        logic [31:0] pc;
    } ment_t;

    ment_t       q[$];
    rob_tag_t    m_next;
    logic        m_pend;
    logic [31:0] m_pc;
    logic        e_we, e_flush;
    logic [4:0]  e_reg;
    logic [31:0] e_data, e_fpc;
    rob_tag_t    e_tag;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
        end
    endtask

    // Program-order queue: entries leave from the front once done, a mispredict arms one flush.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q.delete();
            m_next = 1; m_pend = 0; m_pc = 0;
            e_we = 0; e_reg = 0; e_data = 0; e_tag = 0; e_flush = 0; e_fpc = 0;
        end else if (m_pend) begin
            e_flush = 1; e_fpc = m_pc;
            e_we = 0; e_reg = 0; e_data = 0; e_tag = 0;
            q.delete();
            m_next = 1; m_pend = 0;
        end else begin
            logic acc, com;
            acc = rob.dispatch_valid && (q.size() < 15);
            com = (q.size() > 0) && q[0].done;
            e_flush = 0; e_fpc = 0;
            e_we   = com && q[0].hd;
            e_reg  = com ? q[0].rg : 5'd0;
            e_data = com ? q[0].data : 32'd0;
            e_tag  = com ? q[0].tag : rob_tag_t'(0);
            if (rob.cdb_valid)
                foreach (q[i])
                    if (q[i].tag == rob.cdb_rob_id) begin
                        q[i].done = 1;
                        q[i].data = rob.cdb_data;
                        q[i].mp   = rob.cdb_mispredict && q[i].br;
                        q[i].pc   = rob.cdb_redirect_pc;
                    end
            if (com) begin
                if (q[0].mp) begin m_pend = 1; m_pc = q[0].pc; end
                void'(q.pop_front());
            end
            if (acc) begin
                q.push_back('{tag: m_next, hd: rob.dispatch_has_dest, rg: rob.dispatch_reg_id,
                              br: rob.dispatch_is_branch, done: 0, data: 0, mp: 0, pc: 0});
                m_next = (m_next == rob_tag_t'(15)) ? rob_tag_t'(1) : m_next + 1'b1;
            end
        end
    end

    function automatic void qexp(input rob_tag_t t, output logic r, output logic [31:0] d);
        r = 0; d = 0;
        foreach (q[i])
            if (q[i].tag == t) begin
                if (q[i].done) begin r = 1; d = q[i].data; end
`ifdef ROB_BYPASS_EN
                if (rob.cdb_valid && rob.cdb_rob_id == t) begin r = 1; d = rob.cdb_data; end
`endif
            end
    endfunction

    always @(negedge clk) begin
        logic er;
        logic [31:0] ed;
        if (rst_n) begin
            chk("dispatch_ready", 32'(rob.dispatch_ready), 32'(!m_pend && q.size() < 15));
            chk("dispatch_rob_id", 32'(rob.dispatch_rob_id), 32'(m_next));
            chk("to_rf_we", 32'(rob.to_rf_write_enabled), 32'(e_we));
            chk("to_rf_reg", 32'(rob.to_rf_reg_id), 32'(e_reg));
            chk("to_rf_data", rob.to_rf_data, e_data);
            chk("to_rf_tag", 32'(rob.to_rf_rob_id), 32'(e_tag));
            chk("flush_out", 32'(rob.flush_out), 32'(e_flush));
            chk("flush_pc", rob.flush_pc_out, e_fpc);
            qexp(rob.query_rob_id_a, er, ed);
            chk("query_ready_a", 32'(rob.query_ready_a), 32'(er));
            if (er || rob.query_rob_id_a == NO_TAG) chk("query_data_a", rob.query_data_a, ed);
            qexp(rob.query_rob_id_b, er, ed);
            chk("query_ready_b", 32'(rob.query_ready_b), 32'(er));
            if (er || rob.query_rob_id_b == NO_TAG) chk("query_data_b", rob.query_data_b, ed);
        end
    end

    task automatic tick();
        @(posedge clk); #1;
    endtask

    task automatic idle();
        rob.dispatch_valid = 0; rob.dispatch_has_dest = 0; rob.dispatch_reg_id = 0;
        rob.dispatch_is_branch = 0; rob.cdb_valid = 0; rob.cdb_rob_id = 0; rob.cdb_data = 0;
        rob.cdb_mispredict = 0; rob.cdb_redirect_pc = 0; rob.query_rob_id_a = 0; rob.query_rob_id_b = 0;
    endtask

    task automatic do_reset();
        idle();
        rst_n = 0; #2; rst_n = 1;
    endtask

    task automatic cdb(input int tag, input logic [31:0] data, input logic mp, input logic [31:0] pc);
        rob.cdb_valid = 1; rob.cdb_rob_id = rob_tag_t'(tag); rob.cdb_data = data;
        rob.cdb_mispredict = mp; rob.cdb_redirect_pc = pc;
        tick();
        rob.cdb_valid = 0; rob.cdb_mispredict = 0;
    endtask

    task automatic disp(input logic [4:0] rg, input logic br);
        rob.dispatch_valid = 1; rob.dispatch_has_dest = 1; rob.dispatch_reg_id = rg; rob.dispatch_is_branch = br;
        tick();
        rob.dispatch_valid = 0; rob.dispatch_is_branch = 0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        idle();
        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_ready", 32'(rob.dispatch_ready), 32'd1);
        chk("rst_rob_id", 32'(rob.dispatch_rob_id), 32'd1);
        chk("rst_we", 32'(rob.to_rf_write_enabled), 32'd0);
        chk("rst_flush", 32'(rob.flush_out), 32'd0);
        chk("rst_data", rob.to_rf_data, 32'd0);
        tick(); rst_n = 1;

        // Single instruction round trip.
        rob.dispatch_valid = 1; rob.dispatch_has_dest = 1; rob.dispatch_reg_id = 5;
        @(negedge clk); chk("t1_disp_id", 32'(rob.dispatch_rob_id), 32'd1);
        tick(); rob.dispatch_valid = 0;
        cdb(1, 32'hDEADBEEF, 0, 0);
        @(negedge clk); chk("t1_no_early_commit", 32'(rob.to_rf_write_enabled), 32'd0);
        tick(); @(negedge clk);
        chk("t1_we", 32'(rob.to_rf_write_enabled), 32'd1);
        chk("t1_reg", 32'(rob.to_rf_reg_id), 32'd5);
        chk("t1_data", rob.to_rf_data, 32'hDEADBEEF);
        chk("t1_tag", 32'(rob.to_rf_rob_id), 32'd1);
        tick(); @(negedge clk); chk("t1_strobe_once", 32'(rob.to_rf_write_enabled), 32'd0);

        // Fill to 15, then free one slot while dispatch keeps pushing.
        do_reset();
        rob.dispatch_valid = 1; rob.dispatch_has_dest = 1;
        for (int i = 0; i < 15; i++) begin rob.dispatch_reg_id = 5'(i + 1); tick(); end
        @(negedge clk); chk("t2_full", 32'(rob.dispatch_ready), 32'd0);
        rob.cdb_valid = 1; rob.cdb_rob_id = 1; rob.cdb_data = 32'h111;
        tick(); rob.cdb_valid = 0;
        @(negedge clk); chk("t2_still_full", 32'(rob.dispatch_ready), 32'd0);
        tick(); @(negedge clk);
        chk("t2_commit_tag", 32'(rob.to_rf_rob_id), 32'd1);
        chk("t2_ready_after", 32'(rob.dispatch_ready), 32'd1);
        tick(); rob.dispatch_valid = 0;
        @(negedge clk); chk("t2_refull", 32'(rob.dispatch_ready), 32'd0);

        // Streaming wrap: 40 instructions, each completed the cycle after dispatch.
        do_reset();
        for (int i = 0; i < 40; i++) begin
            rob.dispatch_valid = 1; rob.dispatch_has_dest = 1; rob.dispatch_reg_id = 5'(i);
            if (i > 0) begin
                rob.cdb_valid = 1; rob.cdb_rob_id = rob_tag_t'((i - 1) % 15 + 1); rob.cdb_data = 32'h1000 + 32'(i - 1);
            end
            if (i == 14 || i == 15) begin
                @(negedge clk); chk("t3_wrap_id", 32'(rob.dispatch_rob_id), (i == 14) ? 32'd15 : 32'd1);
            end
            tick();
        end
        rob.dispatch_valid = 0;
        cdb(10, 32'h1027, 0, 0);
        tick(); @(negedge clk);
        chk("t3_last_tag", 32'(rob.to_rf_rob_id), 32'd10);
        chk("t3_last_data", rob.to_rf_data, 32'h1027);

        // Out-of-order completion (plus ignored tag 0 / idle-slot broadcasts).
        do_reset();
        for (int k = 1; k <= 3; k++) disp(5'(k), 0);
        cdb(0, 32'hBAD0, 0, 0);
        cdb(9, 32'hBAD9, 0, 0);
        cdb(3, 32'h303, 0, 0);
        cdb(2, 32'h302, 0, 0);
        cdb(1, 32'h301, 0, 0);
        for (int k = 1; k <= 3; k++) begin
            tick(); @(negedge clk);
            chk("t4_order_tag", 32'(rob.to_rf_rob_id), 32'(k));
            chk("t4_order_data", rob.to_rf_data, 32'h300 + 32'(k));
        end

        // Mispredicted branch at head: write first, flush next cycle.
        do_reset();
        disp(1, 1);
        disp(2, 0);
        cdb(1, 32'h55, 1, 32'h80);
        tick(); @(negedge clk);
        chk("t5_we", 32'(rob.to_rf_write_enabled), 32'd1);
        chk("t5_reg", 32'(rob.to_rf_reg_id), 32'd1);
        chk("t5_no_flush_yet", 32'(rob.flush_out), 32'd0);
        chk("t5_pend_not_ready", 32'(rob.dispatch_ready), 32'd0);
        tick(); @(negedge clk);
        chk("t5_flush", 32'(rob.flush_out), 32'd1);
        chk("t5_flush_pc", rob.flush_pc_out, 32'h80);
        chk("t5_id_after", 32'(rob.dispatch_rob_id), 32'd1);
        tick(); @(negedge clk); chk("t5_flush_once", 32'(rob.flush_out), 32'd0);

        // Query against a same-cycle broadcast.
        do_reset();
        disp(3, 0);
        disp(4, 0);
        rob.query_rob_id_a = 2; rob.query_rob_id_b = 1;
        rob.cdb_valid = 1; rob.cdb_rob_id = 2; rob.cdb_data = 32'h22;
        @(negedge clk);
`ifdef ROB_BYPASS_EN
        chk("t6_bypass_ready", 32'(rob.query_ready_a), 32'd1);
`else
        chk("t6_bypass_ready", 32'(rob.query_ready_a), 32'd0);
`endif
        tick(); rob.cdb_valid = 0;
        @(negedge clk);
        chk("t6_ready_a", 32'(rob.query_ready_a), 32'd1);
        chk("t6_data_a", rob.query_data_a, 32'h22);
        chk("t6_ready_b", 32'(rob.query_ready_b), 32'd0);
        rob.query_rob_id_a = 0; rob.query_rob_id_b = 0;

        // Reset while a flush is pending cancels it.
        do_reset();
        disp(7, 1);
        cdb(1, 32'h77, 1, 32'h44);
        tick();
        rst_n = 0; #2; rst_n = 1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk); chk("t7_no_flush", 32'(rob.flush_out), 32'd0);
            tick();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
